// File: rtl/piano_pkg.sv
// Shared definitions for the piano playback path: key codes, song-entry
// field layout, default widths and the playback sequencer state type.
package piano_pkg;

  localparam int TIME_W    = 13;
  localparam int ADDR_W    = 13;
  localparam int ENTRY_W   = 28;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_DO   = 2'b01;
  localparam logic [1:0] KEY_RE   = 2'b10;
  localparam logic [1:0] KEY_MI   = 2'b11;

  // Entry layout: {key[27:26], start[25:13], duration[12:0]}
  localparam int KEY_MSB   = 27;
  localparam int START_LSB = 13;
  localparam int DUR_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_WAIT,
    S_SOUND,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/play_timer.sv
// Elapsed playback time in 0.01 s units: cleared on restart, advanced by the
// tick strobe while enabled, and held at all-ones once it saturates.
module play_timer #(
  parameter int TIME_W = piano_pkg::TIME_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic              enable_i,
  output logic [TIME_W-1:0] elapsed_o
);

  logic [TIME_W-1:0] elapsed_q, elapsed_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    elapsed_d = elapsed_q;
    if (clear_i) begin
      elapsed_d = '0;
    end else if (tick_i && enable_i && (elapsed_q != '1)) begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/song_player.sv
// Song playback sequencer: walks the song RAM in address order and sounds each
// entry's key while the elapsed time lies inside that entry's window.
module song_player #(
  parameter int ADDR_W    = piano_pkg::ADDR_W,
  parameter int TIME_W    = piano_pkg::TIME_W,
  parameter int LAST_ADDR = 8191
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              tick,
  input  logic              play,
  input  logic              stop,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [27:0]       rd_data,
  output logic [1:0]        key_out,
  output logic              playing,
  output logic              done
);

  import piano_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        key_out_q, key_out_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;
  logic [1:0]        key_q, key_d;
  logic [TIME_W-1:0] start_q, start_d;
  logic [TIME_W:0]   end_q, end_d;

  logic [TIME_W-1:0] elapsed;
  logic [TIME_W:0]   elapsed_ext;
  logic [1:0]        ent_key;
  logic [TIME_W-1:0] ent_start, ent_dur;
  logic [TIME_W:0]   ent_end;

  assign ent_key     = rd_data[KEY_MSB -: 2];
  assign ent_start   = rd_data[START_LSB +: TIME_W];
  assign ent_dur     = rd_data[DUR_LSB +: TIME_W];
  // One extra bit keeps start+dur from wrapping.
  assign ent_end     = {1'b0, ent_start} + {1'b0, ent_dur};
  assign elapsed_ext = {1'b0, elapsed};

  play_timer #(.TIME_W(TIME_W)) u_timer (
    .clock     (clock),
    .resetn    (resetn),
    .clear_i   (play),
    .tick_i    (tick),
    .enable_i  (playing_q),
    .elapsed_o (elapsed)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    key_out_d = key_out_q;
    playing_d = playing_q;
    done_d    = 1'b0;
    key_d     = key_q;
    start_d   = start_q;
    end_d     = end_q;

    unique case (state_q)
      S_IDLE: ;
      S_ADDR: state_d = S_LATCH;
      S_LATCH: begin
        key_d   = ent_key;
        start_d = ent_start;
        end_d   = ent_end;
        if (ent_dur == '0)                state_d = S_DONE;
        else if (ent_end <= elapsed_ext)  state_d = S_NEXT;
        else if (ent_start <= elapsed)    state_d = S_SOUND;
        else                              state_d = S_WAIT;
      end
      S_WAIT: begin
        key_out_d = KEY_NONE;
        if (elapsed >= start_q) begin
          state_d   = S_SOUND;
          key_out_d = key_q;
        end
      end
      S_SOUND: begin
        key_out_d = key_q;
        if (elapsed_ext >= end_q) begin
          state_d   = S_NEXT;
          key_out_d = KEY_NONE;
        end
      end
      S_NEXT: begin
        if (addr_q == ADDR_W'(LAST_ADDR)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        playing_d = 1'b0;
        key_out_d = KEY_NONE;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart outranks abort; both cancel any pending done pulse.
    if (play) begin
      state_d   = S_ADDR;
      addr_d    = '0;
      key_out_d = KEY_NONE;
      playing_d = 1'b1;
      done_d    = 1'b0;
    end else if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      key_out_d = KEY_NONE;
      playing_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      key_out_q <= KEY_NONE;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      key_q     <= KEY_NONE;
      start_q   <= '0;
      end_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      key_out_q <= key_out_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      key_q     <= key_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end

  assign rd_addr = addr_q;
  assign key_out = key_out_q;
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player: a song-level model predicts the sounding
// key from the entry table and tick count; literal checks pin exact timing.
module tb_song_player;

  localparam int LAST = 3;

  logic        clock = 1'b0;
  logic        resetn, tick, play, stop;
  logic [12:0] rd_addr;
  logic [27:0] rd_data;
  logic [1:0]  key_out;
  logic        playing, done;

  logic [27:0] mem [0:8191];

  always #10 clock = ~clock;
  always @(posedge clock) rd_data <= mem[rd_addr];

  song_player #(.LAST_ADDR(LAST)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .tick    (tick),
    .play    (play),
    .stop    (stop),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .key_out (key_out),
    .playing (playing),
    .done    (done)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;

  int m_t = 0;
  bit m_active = 1'b0;
  bit m_fin = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] ent(input int k, input int s, input int d);
    logic [1:0]  kk;
    logic [12:0] ss, dd;
    kk = 2'(k);
    ss = 13'(s);
    dd = 13'(d);
    return {kk, ss, dd};
  endfunction

  // Song-level view: at time t the sounding entry is the first in address
  // order whose window has not yet closed; a terminator or running past the
  // last address means the song is over.
  function automatic void model_eval(input int t, output logic [1:0] k, output bit fin);
    logic [27:0] e;
    int st, du;
    k = 2'b00;
    fin = 1'b0;
    for (int a = 0; a <= LAST; a++) begin
      e  = mem[a];
      st = int'(e[25:13]);
      du = int'(e[12:0]);
      if (du == 0) begin
        fin = 1'b1;
        return;
      end
      if (st + du > t) begin
        k = (st <= t) ? e[27:26] : 2'b00;
        return;
      end
    end
    fin = 1'b1;
  endfunction

  always @(negedge clock) begin
    logic [1:0] k;
    bit f;
    if (done === 1'b1) done_cnt++;
    if (resetn === 1'b1) check("rd_addr_bound", 32'(rd_addr > 13'(LAST)), 32'd0);
    if (chk_en) begin
      model_eval(m_t, k, f);
      check("key_out", 32'(key_out), (m_active && !m_fin) ? 32'(k) : 32'd0);
      check("playing", 32'(playing), 32'(m_active && !m_fin));
    end
  end

  task automatic load(input logic [27:0] e0, e1, e2, e3);
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[0] = e0;
    mem[1] = e1;
    mem[2] = e2;
    mem[3] = e3;
  endtask

  task automatic settle();
    chk_en = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    chk_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic do_play(input bit with_tick);
    logic [1:0] k;
    chk_en = 1'b0;
    play = 1'b1;
    tick = with_tick;
    @(posedge clock);
    #1;
    play = 1'b0;
    tick = 1'b0;
    m_t = 0;
    m_active = 1'b1;
    model_eval(m_t, k, m_fin);
    if (m_fin) exp_done++;
    settle();
  endtask

  task automatic do_tick();
    logic [1:0] k;
    bit f;
    chk_en = 1'b0;
    tick = 1'b1;
    @(posedge clock);
    #1;
    tick = 1'b0;
    if (m_active && !m_fin) begin
      if (m_t < 8191) m_t++;
      model_eval(m_t, k, f);
      if (f) begin
        m_fin = 1'b1;
        exp_done++;
      end
    end
    settle();
  endtask

  task automatic do_stop();
    chk_en = 1'b0;
    stop = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    m_active = 1'b0;
    check("stop_key", 32'(key_out), 32'd0);
    check("stop_playing", 32'(playing), 32'd0);
    settle();
  endtask

  logic [1:0] t1_keys [0:12];
  int d0;

  initial begin
    t1_keys = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    load('0, '0, '0, '0);
    resetn = 1'b0;
    tick = 1'b0;
    play = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_key", 32'(key_out), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    settle();

    // Two notes with a gap, then terminator.
    load(ent(1, 5, 3), ent(2, 10, 2), ent(0, 0, 0), '0);
    do_play(1'b0);
    check("t1_key_t0", 32'(key_out), 32'(t1_keys[0]));
    for (int i = 1; i <= 12; i++) begin
      do_tick();
      check($sformatf("t1_key_t%0d", i), 32'(key_out), 32'(t1_keys[i]));
    end
    check("t1_playing_end", 32'(playing), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Exact latency from play to first key.
    load(ent(3, 0, 4), ent(0, 0, 0), '0, '0);
    chk_en = 1'b0;
    play = 1'b1;
    @(posedge clock);
    #1;
    play = 1'b0;
    check("t2_playing_n", 32'(playing), 32'd1);
    check("t2_addr_n", 32'(rd_addr), 32'd0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("t2_key_n2", 32'(key_out), 32'd0);
    @(posedge clock);
    #1;
    check("t2_key_n3", 32'(key_out), 32'd3);
    m_t = 0;
    m_active = 1'b1;
    m_fin = 1'b0;
    settle();
    for (int i = 1; i <= 4; i++) do_tick();
    check("t2_key_t4", 32'(key_out), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // Second entry's window closes inside the first: skipped.
    load(ent(1, 0, 10), ent(2, 3, 2), ent(0, 0, 0), '0);
    do_play(1'b0);
    for (int i = 1; i <= 9; i++) do_tick();
    check("t3_key_t9", 32'(key_out), 32'd1);
    do_tick();
    check("t3_key_t10", 32'(key_out), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // Abort mid-note, then restart with a coincident tick.
    load(ent(2, 0, 5), ent(0, 0, 0), '0, '0);
    do_play(1'b0);
    do_tick();
    do_tick();
    check("t4_key_before_stop", 32'(key_out), 32'd2);
    d0 = done_cnt;
    do_stop();
    check("t4_no_done", 32'(done_cnt), 32'(d0));
    do_play(1'b1);
    check("t4_restart_key", 32'(key_out), 32'd2);
    for (int i = 1; i <= 4; i++) do_tick();
    check("t4_key_t4", 32'(key_out), 32'd2);
    do_tick();
    check("t4_key_t5", 32'(key_out), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // No terminator: playback ends after the last scanned address.
    load(ent(1, 0, 1), ent(2, 1, 1), ent(3, 2, 1), ent(1, 3, 1));
    mem[4] = ent(2, 0, 100);
    d0 = done_cnt;
    do_play(1'b0);
    for (int i = 1; i <= 4; i++) do_tick();
    check("t5_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("t5_addr_last", 32'(rd_addr), 32'd3);
    check("t5_playing", 32'(playing), 32'd0);

    // Asynchronous reset while sounding at a non-zero address.
    mem[4] = '0;
    do_play(1'b0);
    do_tick();
    do_tick();
    check("t6_key_pre", 32'(key_out), 32'd3);
    check("t6_addr_pre", 32'(rd_addr), 32'd2);
    chk_en = 1'b0;
    #3;
    resetn = 1'b0;
    m_active = 1'b0;
    #1;
    check("t6_rst_key", 32'(key_out), 32'd0);
    check("t6_rst_addr", 32'(rd_addr), 32'd0);
    check("t6_rst_playing", 32'(playing), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    settle();

    check("done_total", 32'(done_cnt), 32'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
